// File: rtl/cpu7_ifu_fq_if.sv
// Fetch-queue bundle: memory request/response, redirect inputs and decode handshake.
// Latency: none (wires only).
// Backpressure: inst_addr_ok throttles requests, fdp_dec_rdy throttles the decode side.
// Ports: master = fetch queue (drives inst_req/inst_addr/inst_cancel and fdp_dec_*),
//        slave  = environment (memory, execute-stage redirects, decode).
interface cpu7_ifu_fq_if #(
  parameter int GRLEN = 32
);
  logic             inst_req;
  logic [GRLEN-1:0] inst_addr;
  logic             inst_addr_ok;
  logic             inst_cancel;
  logic             inst_valid_f;
  logic [31:0]      inst_rdata_f;
  logic             inst_ex;
  logic [5:0]       inst_exccode;
  logic             exu_ifu_except;
  logic [GRLEN-1:0] exu_ifu_eentry;
  logic             exu_ifu_ertn_e;
  logic [GRLEN-1:0] exu_ifu_era;
  logic             br_taken;
  logic [GRLEN-1:0] br_target;
  logic             fdp_dec_vld;
  logic             fdp_dec_rdy;
  logic [GRLEN-1:0] fdp_dec_pc;
  logic [31:0]      fdp_dec_inst;
  logic             fdp_dec_ex;
  logic [5:0]       fdp_dec_exccode;

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_valid_f, inst_rdata_f, inst_ex, inst_exccode,
    input  exu_ifu_except, exu_ifu_eentry, exu_ifu_ertn_e, exu_ifu_era,
    input  br_taken, br_target,
    output fdp_dec_vld, fdp_dec_pc, fdp_dec_inst, fdp_dec_ex, fdp_dec_exccode,
    input  fdp_dec_rdy
  );

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_valid_f, inst_rdata_f, inst_ex, inst_exccode,
    output exu_ifu_except, exu_ifu_eentry, exu_ifu_ertn_e, exu_ifu_era,
    output br_taken, br_target,
    input  fdp_dec_vld, fdp_dec_pc, fdp_dec_inst, fdp_dec_ex, fdp_dec_exccode,
    output fdp_dec_rdy
  );
endinterface

// File: rtl/cpu7_ifu_fq.sv
// IFU fetch queue: issues fetch PCs with up to MAX_OS in flight, buffers DEPTH responses in order.
// Latency: response visible at decode 1 cycle after inst_valid_f (0 cycles with IFU_FQ_BYPASS_EN).
// Backpressure: requests stop when outstanding+queued reaches DEPTH; decode stalls via fdp_dec_rdy.
// Ports: clk, reset (async, active high), bus (cpu7_ifu_fq_if.master).
// Optional macro IFU_FQ_BYPASS_EN: empty-queue responses go straight to decode in the same cycle.
module cpu7_ifu_fq #(
  parameter int               GRLEN    = 32,
  parameter int               DEPTH    = 4,
  parameter int               PTR_W    = 2,
  parameter int               MAX_OS   = 2,
  parameter logic [GRLEN-1:0] RESET_PC = 'h1c000000
) (
  input  logic          clk,
  input  logic          reset,
  cpu7_ifu_fq_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OS_W  = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;

  typedef struct packed {
    logic [GRLEN-1:0] pc;
    logic [31:0]      inst;
    logic             ex;
    logic [5:0]       exccode;
  } fq_entry_t;

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  state_t           state, state_nxt;
  logic [GRLEN-1:0] fetch_pc, redir_tgt;
  logic [CNT_W-1:0] os_cnt, os_nxt, drop_cnt, drop_nxt, q_cnt;
  fq_entry_t        q_mem [DEPTH];
  logic [PTR_W-1:0] q_rd, q_wr;
  logic [GRLEN-1:0] pcq_mem [MAX_OS];
  logic [OS_W-1:0]  pcq_rd, pcq_wr;

  logic      redirect, credit_ok, req_int, accept, pop, resp_live;
  logic      enq, deq_q, dec_vld_int, dec_vld_out;
  fq_entry_t resp_entry, head;

  assign redirect = bus.exu_ifu_except | bus.exu_ifu_ertn_e | bus.br_taken;

  always_comb begin
    redir_tgt = bus.br_target;
    if (bus.exu_ifu_except)      redir_tgt = bus.exu_ifu_eentry;
    else if (bus.exu_ifu_ertn_e) redir_tgt = bus.exu_ifu_era;
  end

  // Every outstanding request owns a queue slot, so the queue can never overflow.
  assign credit_ok = (os_cnt < CNT_W'(MAX_OS)) &&
                     (({1'b0, os_cnt} + {1'b0, q_cnt}) < (CNT_W + 1)'(DEPTH));
  assign req_int   = (state == ST_RUN) & ~redirect & credit_ok;
  assign accept    = req_int & bus.inst_addr_ok;

  // Stale PCs stay in the PC FIFO after a redirect and pop as their dropped responses return.
  assign pop       = bus.inst_valid_f & (os_cnt != '0);
  assign resp_live = bus.inst_valid_f & ~redirect & (drop_cnt == '0);
  assign resp_entry = '{pc: pcq_mem[pcq_rd], inst: bus.inst_rdata_f,
                        ex: bus.inst_ex, exccode: bus.inst_exccode};

`ifdef IFU_FQ_BYPASS_EN
  logic byp;
  assign byp         = resp_live & (q_cnt == '0);
  assign dec_vld_int = ~redirect & ((q_cnt != '0) | byp);
  assign head        = byp ? resp_entry : q_mem[q_rd];
  assign enq         = resp_live & ~(byp & bus.fdp_dec_rdy);
`else
  assign dec_vld_int = ~redirect & (q_cnt != '0);
  assign head        = q_mem[q_rd];
  assign enq         = resp_live;
`endif

  assign deq_q       = dec_vld_int & bus.fdp_dec_rdy & (q_cnt != '0);
  assign dec_vld_out = dec_vld_int & ~reset;

  assign bus.inst_req        = req_int & ~reset;
  assign bus.inst_addr       = fetch_pc;
  assign bus.inst_cancel     = redirect & ~reset;
  assign bus.fdp_dec_vld     = dec_vld_out;
  assign bus.fdp_dec_pc      = dec_vld_out ? head.pc      : '0;
  assign bus.fdp_dec_inst    = dec_vld_out ? head.inst    : '0;
  assign bus.fdp_dec_ex      = dec_vld_out ? head.ex      : 1'b0;
  assign bus.fdp_dec_exccode = dec_vld_out ? head.exccode : '0;

  always_comb begin
    os_nxt = os_cnt + CNT_W'(accept) - CNT_W'(pop);
    drop_nxt = drop_cnt;
    if (redirect)
      drop_nxt = os_nxt;
    else if (bus.inst_valid_f && (drop_cnt != '0))
      drop_nxt = drop_cnt - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (redirect)
      state_nxt = ST_RUN;
    else if ((state == ST_RUN) && resp_live && bus.inst_ex)
      state_nxt = ST_HOLD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC;
      os_cnt   <= '0;
      drop_cnt <= '0;
      q_cnt    <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      pcq_rd   <= '0;
      pcq_wr   <= '0;
    end else begin
      state    <= state_nxt;
      os_cnt   <= os_nxt;
      drop_cnt <= drop_nxt;
      if (redirect)
        fetch_pc <= redir_tgt;
      else if (accept)
        fetch_pc <= {fetch_pc[GRLEN-1:2] + (GRLEN - 2)'(1), fetch_pc[1:0]};
      if (accept)
        pcq_wr <= (pcq_wr == OS_W'(MAX_OS - 1)) ? '0 : pcq_wr + 1'b1;
      if (pop)
        pcq_rd <= (pcq_rd == OS_W'(MAX_OS - 1)) ? '0 : pcq_rd + 1'b1;
      if (redirect) begin
        q_cnt <= '0;
        q_rd  <= '0;
        q_wr  <= '0;
      end else begin
        q_cnt <= q_cnt + CNT_W'(enq) - CNT_W'(deq_q);
        if (enq)   q_wr <= q_wr + 1'b1;
        if (deq_q) q_rd <= q_rd + 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (accept) pcq_mem[pcq_wr] <= fetch_pc;
    if (enq)    q_mem[q_wr]     <= resp_entry;
  end
endmodule

// File: tb/tb_cpu7_ifu_fq.sv
// Randomised scoreboard bench for cpu7_ifu_fq: a memory model with in-order latency,
// random redirects, exceptions and decode stalls; a separate monitor checks dequeues.
module tb_cpu7_ifu_fq;
  localparam int GRLEN  = 32;
  localparam int DEPTH  = 4;
  localparam int MAX_OS = 2;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam int NCYC = 3000;
`ifdef IFU_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  code;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          epoch;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  code;
  } mreq_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;

  exp_t  exp_q[$];
  mreq_t mem_q[$];
  exp_t  mon_e;

  logic [31:0] model_pc = RST_PC;
  int          epoch = 0;
  bit          hold = 1'b0;

  cpu7_ifu_fq_if #(.GRLEN(GRLEN)) bus ();

  cpu7_ifu_fq #(.GRLEN(GRLEN), .DEPTH(DEPTH), .PTR_W(2), .MAX_OS(MAX_OS), .RESET_PC(RST_PC))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive_idle();
    bus.inst_addr_ok   = 1'b0;
    bus.inst_valid_f   = 1'b0;
    bus.inst_rdata_f   = '0;
    bus.inst_ex        = 1'b0;
    bus.inst_exccode   = '0;
    bus.exu_ifu_except = 1'b0;
    bus.exu_ifu_eentry = '0;
    bus.exu_ifu_ertn_e = 1'b0;
    bus.exu_ifu_era    = '0;
    bus.br_taken       = 1'b0;
    bus.br_target      = '0;
    bus.fdp_dec_rdy    = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_inst_req", bus.inst_req, 0);
    chk("rst_inst_cancel", bus.inst_cancel, 0);
    chk("rst_inst_addr", bus.inst_addr, RST_PC);
    chk("rst_dec_vld", bus.fdp_dec_vld, 0);
    chk("rst_dec_pc", bus.fdp_dec_pc, 0);
    chk("rst_dec_inst", bus.fdp_dec_inst, 0);
  endtask

  function automatic logic [31:0] rand_tgt();
    return 32'h1c000000 | ($urandom_range(0, 16'hffff) << 2);
  endfunction

  // Decode-side monitor: independent of stimulus, pops the scoreboard on every handshake.
  always @(negedge clk) begin
    #2;
    if (!reset && bus.fdp_dec_vld === 1'b1 && bus.fdp_dec_rdy === 1'b1) begin
      chk("deq_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("deq_pc", bus.fdp_dec_pc, mon_e.pc);
        chk("deq_inst", bus.fdp_dec_inst, mon_e.inst);
        chk("deq_ex", bus.fdp_dec_ex, mon_e.ex);
        chk("deq_exccode", bus.fdp_dec_exccode, mon_e.code);
      end
    end
  end

  initial begin
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs();

    for (int c = 0; c < NCYC; c++) begin
      bit fill, redir, resp, exp_req, exp_vld, pushed;
      int pre;
      logic [31:0] tgt;
      mreq_t m;
      @(negedge clk);

      if (c == 1200 || c == 1201) begin
        reset = 1'b1;
        drive_idle();
        #1;
        chk_reset_outputs();
        mem_q.delete();
        exp_q.delete();
        model_pc = RST_PC;
        hold = 1'b0;
        epoch++;
        continue;
      end
      reset = 1'b0;

      // Stall decode for a while so the queue fills and credits run out.
      fill  = (c >= 300 && c < 360);
      drive_idle();
      redir = !fill && ($urandom_range(0, 14) == 0);
      if (redir) begin
        bus.exu_ifu_except = $urandom_range(0, 1);
        bus.exu_ifu_ertn_e = $urandom_range(0, 1);
        bus.br_taken       = $urandom_range(0, 1);
        if (!bus.exu_ifu_except && !bus.exu_ifu_ertn_e) bus.br_taken = 1'b1;
        bus.exu_ifu_eentry = rand_tgt();
        bus.exu_ifu_era    = rand_tgt();
        bus.br_target      = rand_tgt();
      end
      tgt = bus.exu_ifu_except ? bus.exu_ifu_eentry :
            bus.exu_ifu_ertn_e ? bus.exu_ifu_era : bus.br_target;
      bus.inst_addr_ok = fill ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.fdp_dec_rdy  = fill ? 1'b0 : ($urandom_range(0, 9) < 7);
      resp = (mem_q.size() != 0) && (fill || $urandom_range(0, 3) != 0);
      if (resp) begin
        bus.inst_valid_f = 1'b1;
        bus.inst_rdata_f = mem_q[0].inst;
        bus.inst_ex      = mem_q[0].ex;
        bus.inst_exccode = mem_q[0].code;
      end

      #1;
      exp_req = !redir && !hold && (mem_q.size() < MAX_OS) &&
                (mem_q.size() + exp_q.size() < DEPTH);
      chk("inst_req", bus.inst_req, exp_req);
      chk("inst_cancel", bus.inst_cancel, redir);
      if (exp_req) chk("inst_addr", bus.inst_addr, model_pc);

      pre = exp_q.size();
      pushed = 1'b0;
      if (resp) begin
        m = mem_q.pop_front();
        if (!redir && m.epoch == epoch) begin
          exp_q.push_back('{pc: m.pc, inst: m.inst, ex: m.ex, code: m.code});
          pushed = 1'b1;
          if (m.ex) hold = 1'b1;
        end
      end
      exp_vld = !redir && (pre > 0 || (BYP && pushed));
      chk("dec_vld", bus.fdp_dec_vld, exp_vld);

      if (exp_req && bus.inst_addr_ok) begin
        m.pc    = model_pc;
        m.epoch = epoch;
        m.inst  = $urandom;
        m.ex    = !fill && ($urandom_range(0, 24) == 0);
        m.code  = 6'($urandom_range(0, 63));
        mem_q.push_back(m);
        model_pc = model_pc + 32'd4;
      end

      if (redir) begin
        exp_q.delete();
        epoch++;
        model_pc = tgt;
        hold = 1'b0;
      end
    end

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
